// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding, S-box and round-constant lookups.
// Used by the key schedule engine and its SubWord helper.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Row r holds S(16r) .. S(16r+15), left to right.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    unique case (1'b1)
      (i == 4'd0): r = 8'h01;
      (i == 4'd1): r = 8'h02;
      (i == 4'd2): r = 8'h04;
      (i == 4'd3): r = 8'h08;
      (i == 4'd4): r = 8'h10;
      (i == 4'd5): r = 8'h20;
      (i == 4'd6): r = 8'h40;
      (i == 4'd7): r = 8'h80;
      (i == 4'd8): r = 8'h1b;
      (i == 4'd9): r = 8'h36;
      default:     r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_sub_word.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
// Shares the S-box table used by SubBytes.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {sbox(word_i[31:24]),
                   sbox(word_i[23:16]),
                   sbox(word_i[15:8]),
                   sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_expand_seq.sv
// AES-128 key schedule: one round key per stream beat, indices 0..10.
// AES_KEY_STORE_EN adds an 11-entry round-key store with a registered read port.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_index,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
`ifdef AES_KEY_STORE_EN
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             keys_loaded,
`endif
  output logic             busy
);

  if (NR != AES_NR || KEY_W != AES_KEY_W) begin : g_bad_cfg
    $error("aes_key_expand_seq supports only NR=10, KEY_W=128");
  end

  state_e           state_q, state_d;
  logic [KEY_W-1:0] rk_out_q, rk_out_d;
  logic [3:0]       rk_index_q, rk_index_d;
  logic             rk_valid_q, rk_valid_d;

  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      sub_w, temp;
  logic [31:0]      n0, n1, n2, n3;
  logic             key_hs, rk_hs, at_last;

  assign w0 = rk_out_q[127:96];
  assign w1 = rk_out_q[95:64];
  assign w2 = rk_out_q[63:32];
  assign w3 = rk_out_q[31:0];

  aes_sub_word u_sub_word (
    .word_i ({w3[23:0], w3[31:24]}),
    .word_o (sub_w)
  );

  assign temp = sub_w ^ {rcon(rk_index_q), 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q == EMIT);
  assign rk_out    = rk_out_q;
  assign rk_index  = rk_index_q;
  assign rk_valid  = rk_valid_q;
  assign at_last   = (rk_index_q == 4'(NR));
  assign rk_last   = rk_valid_q && at_last;
  assign key_hs    = key_valid && key_ready;
  assign rk_hs     = rk_valid_q && rk_ready;

  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out_q;
    rk_index_d = rk_index_q;
    rk_valid_d = rk_valid_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          rk_out_d   = key_in;
          rk_index_d = 4'd0;
          rk_valid_d = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (rk_hs) begin
          if (at_last) begin
            rk_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            rk_out_d   = {n0, n1, n2, n3};
            rk_index_d = rk_index_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rk_out_q   <= '0;
      rk_index_q <= 4'd0;
      rk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_out_q   <= rk_out_d;
      rk_index_q <= rk_index_d;
      rk_valid_q <= rk_valid_d;
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [KEY_W-1:0] store_q [NR+1];
  logic [KEY_W-1:0] rd_key_q, rd_key_d;
  logic             keys_loaded_q, keys_loaded_d;

  assign rd_key      = rd_key_q;
  assign keys_loaded = keys_loaded_q;

  always_comb begin
    rd_key_d      = '0;
    keys_loaded_d = keys_loaded_q;
    if (rd_idx <= 4'(NR)) begin
      rd_key_d = store_q[rd_idx];
    end
    if (key_hs) begin
      keys_loaded_d = 1'b0;
    end
    if (rk_hs && at_last) begin
      keys_loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) begin
        store_q[i] <= '0;
      end
      rd_key_q      <= '0;
      keys_loaded_q <= 1'b0;
    end else begin
      if (rk_hs) begin
        store_q[rk_index_q] <= rk_out_q;
      end
      rd_key_q      <= rd_key_d;
      keys_loaded_q <= keys_loaded_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboard bench for aes_key_expand_seq; reference model derives the
// S-box from GF(2^8) inversion and expands keys word by word.
module tb_aes_key_expand_seq;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         rk_last;
  logic         busy;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;
  logic         keys_loaded;
`endif

  aes_key_expand_seq dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .rk_out      (rk_out),
    .rk_index    (rk_index),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_last     (rk_last),
`ifdef AES_KEY_STORE_EN
    .rd_idx      (rd_idx),
    .rd_key      (rd_key),
    .keys_loaded (keys_loaded),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] cap [11];
  logic [7:0]   sbox_m [256];
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic check(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  // Standard FIPS-197 word recurrence over w[0..43].
  task automatic model_push(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_t        e;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]],
             sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.idx = 4'(r);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rk_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", {124'h0, rk_index}, 128'h0);
        end else begin
          check(rk_out == exp_q[0].key, "rk_out", rk_out, exp_q[0].key);
          check(rk_index == exp_q[0].idx, "rk_index",
                {124'h0, rk_index}, {124'h0, exp_q[0].idx});
          check(rk_last == (exp_q[0].idx == 4'd10), "rk_last",
                {127'h0, rk_last}, {127'h0, exp_q[0].idx == 4'd10});
          if (rk_ready) begin
            cap[exp_q[0].idx] = rk_out;
            void'(exp_q.pop_front());
          end
        end
      end
      if (key_valid && key_ready) model_push(key_in);
    end
  end

  task automatic send_key(input logic [127:0] k);
    bit got;
    got = 1'b0;
    key_in    = k;
    key_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (key_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    if (!got) check(1'b0, "key_accept_timeout", 128'h0, 128'h1);
  endtask

  task automatic wait_done(input bit rnd);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 2000 && !got; t++) begin
      @(posedge clk); #1;
      rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (exp_q.size() == 0 && !rk_valid) got = 1'b1;
    end
    rk_ready = 1'b1;
    if (!got) check(1'b0, "drain_timeout", 128'(exp_q.size()), 128'h0);
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(rk_valid == 1'b0 && rk_index == 4'd0 && busy == 1'b0 &&
          rk_last == 1'b0, "reset_ctrl",
          {121'h0, rk_valid, rk_index, busy, rk_last}, 128'h0);
    check(rk_out == '0, "reset_rk_out", rk_out, 128'h0);
    check(key_ready == 1'b1, "reset_key_ready", {127'h0, key_ready}, 128'h1);

    // FIPS key, full rate
    rk_ready = 1'b1;
    send_key(FIPS_KEY);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      check(rk_valid && rk_index == 4'(i), "consecutive_beat",
            {123'h0, rk_valid, rk_index}, {123'h0, 1'b1, 4'(i)});
    end
    @(negedge clk);
    check(!rk_valid && key_ready, "idle_after_last",
          {126'h0, rk_valid, key_ready}, 128'h1);
    check(cap[0] == FIPS_KEY, "fips_idx0", cap[0], FIPS_KEY);
    check(cap[1] == FIPS_R1, "fips_idx1", cap[1], FIPS_R1);
    check(cap[10] == FIPS_R10, "fips_idx10", cap[10], FIPS_R10);

`ifdef AES_KEY_STORE_EN
    @(posedge clk); #1 rd_idx = 4'd10;
    @(posedge clk); #1;
    check(rd_key == FIPS_R10, "store_rd10", rd_key, FIPS_R10);
    check(keys_loaded == 1'b1, "keys_loaded", {127'h0, keys_loaded}, 128'h1);
    rd_idx = 4'd11;
    @(posedge clk); #1;
    check(rd_key == '0, "store_rd11", rd_key, 128'h0);
`endif

    // Backpressure at index 4
    cap[10] = '0;
    send_key(FIPS_KEY);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      if (rk_valid && rk_index == 4'd4) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check(hit, "reach_idx4", {127'h0, hit}, 128'h1);
    rk_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rk_ready = 1'b1;
    wait_done(1'b0);
    check(cap[10] == FIPS_R10, "stall_idx10", cap[10], FIPS_R10);

    // Busy reject: all-ones key held during EMIT
    send_key(FIPS_KEY);
    key_in    = '1;
    key_valid = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      check(!key_ready, "busy_reject", {127'h0, key_ready}, 128'h0);
    end
    @(negedge clk);
    check(key_ready, "reaccept_ready", {127'h0, key_ready}, 128'h1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_done(1'b0);
    check(cap[0] == '1, "new_key_idx0", cap[0], '1);

    // Reset at index 6
    send_key(FIPS_KEY);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      if (rk_valid && rk_index == 4'd6) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check(hit, "reach_idx6", {127'h0, hit}, 128'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(!rk_valid && rk_index == 4'd0 && key_ready && !busy, "midreset_ctrl",
          {121'h0, rk_valid, rk_index, key_ready, busy}, 128'h2);
    check(rk_out == '0, "midreset_rk_out", rk_out, 128'h0);
    repeat (3) @(negedge clk);
    check(!rk_valid, "no_partial_after_reset", {127'h0, rk_valid}, 128'h0);

    // Zero key
    send_key('0);
    wait_done(1'b0);
    check(cap[1] == ZERO_R1, "zero_idx1", cap[1], ZERO_R1);

    // Random keys, random backpressure
    for (int n = 0; n < 6; n++) begin
      send_key({$urandom, $urandom, $urandom, $urandom});
      wait_done(1'b1);
    end
    check(exp_q.size() == 0, "scoreboard_empty", 128'(exp_q.size()), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
